// File: rtl/mip_trilinear_seq.sv
// mip_trilinear_seq
//   Takes one fragment per handshake (normalized u/v plus the integer and
//   fractional LOD from the LOD stage). It clamps the LOD and then issues one
//   bilinear footprint request (single level) or two back-to-back requests
//   (trilinear: level L, then level L+1) to the texel fetch stage.
//   Texture wrap mode is repeat.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   fragment handshake
//   in_u, in_v          Q0.16 normalized coordinates
//   in_lod_int/frac     integer LOD and Q0.8 fractional LOD
//   cfg_log2_w/h        log2 of base width/height (quasi-static)
//   cfg_max_level       highest valid mip level
//   req_valid/ready     request handshake
//   req_level           mip level of the request
//   req_x0/x1/y0/y1     texel footprint, already wrapped
//   req_wx/wy           Q0.8 bilinear weights toward x1/y1
//   req_lerp            Q0.8 blend weight toward level+1 (0 if single level)
//   req_last            final request of the fragment

// One axis of the footprint at a given level. It maps a Q0.16 coordinate to
// texel indices and a weight, using the half-texel centre offset and repeat
// wrap.
module mip_axis_geom #(
  parameter int LW     = 4,
  parameter int MAXLOG = 11
) (
  input  logic [15:0]       coord,
  input  logic [3:0]        log2_base,
  input  logic [LW-1:0]     level,
  output logic [MAXLOG-1:0] t0,
  output logic [MAXLOG-1:0] t1,
  output logic [7:0]        w
);
  localparam int CW = 17 + MAXLOG;
  localparam int EW = (LW > 4) ? LW : 4;

  logic [EW-1:0]     lg_e, lvl_e, lw_e;
  logic [3:0]        lw;
  logic [CW-1:0]     cx;
  logic [MAXLOG-1:0] mask;
  logic              unused_bits;

  always_comb begin
    lg_e  = EW'(log2_base);
    lvl_e = EW'(level);
    lw_e  = (lg_e > lvl_e) ? (lg_e - lvl_e) : '0;
    lw    = 4'(lw_e);
    // Two's complement wrap gives the same low bits as the signed
    // subtraction, so the floor by 2^16 and the mask by W-1 reduce to a
    // slice and an AND.
    cx    = (CW'(coord) << lw) - CW'(32'h8000);
    mask  = MAXLOG'((32'd1 << lw) - 32'd1);
    t0    = cx[16 +: MAXLOG] & mask;
    t1    = (t0 + MAXLOG'(1)) & mask;
    // A 1-texel level has nothing to filter.
    w     = (lw == 4'd0) ? 8'd0 : cx[15:8];
  end

  assign unused_bits = ^{cx[CW-1], cx[7:0]};
endmodule

module mip_trilinear_seq #(
  parameter  int LEVELS = 12,
  parameter  int MAXLOG = 11,
  localparam int LW     = $clog2(LEVELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_u,
  input  logic [15:0]       in_v,
  input  logic [LW-1:0]     in_lod_int,
  input  logic [7:0]        in_lod_frac,
  input  logic [3:0]        cfg_log2_w,
  input  logic [3:0]        cfg_log2_h,
  input  logic [LW-1:0]     cfg_max_level,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [LW-1:0]     req_level,
  output logic [MAXLOG-1:0] req_x0,
  output logic [MAXLOG-1:0] req_x1,
  output logic [MAXLOG-1:0] req_y0,
  output logic [MAXLOG-1:0] req_y1,
  output logic [7:0]        req_wx,
  output logic [7:0]        req_wy,
  output logic [7:0]        req_lerp,
  output logic              req_last
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LVL0 = 2'd1;
  localparam logic [1:0] S_LVL1 = 2'd2;

  logic [1:0]  state;
  logic        fire_in, fire_req;
  logic [LW-1:0] lvl_in, g_level;
  logic        tri_in;

  // Fragment state kept for the second (level L+1) request.
  logic [15:0] cap_u, cap_v;
  logic [3:0]  cap_lw, cap_lh;

  // Axis 0 = x/u/width, axis 1 = y/v/height.
  logic [1:0][15:0]       g_coord;
  logic [1:0][3:0]        g_log2;
  logic [1:0][MAXLOG-1:0] g_t0, g_t1;
  logic [1:0][7:0]        g_w;

  assign fire_req = req_valid && req_ready;
  assign in_ready = !rst && (state == S_IDLE || (fire_req && req_last));
  assign fire_in  = in_valid && in_ready;

  assign lvl_in = (in_lod_int < cfg_max_level) ? in_lod_int : cfg_max_level;
  assign tri_in = (in_lod_frac != 8'd0) && (in_lod_int < cfg_max_level);

  // One geometry unit per axis is shared between the first request (fed
  // from the live inputs) and the second (fed from captured state at
  // req_level+1). An accepted fragment always takes priority.
  always_comb begin
    g_coord[0] = fire_in ? in_u       : cap_u;
    g_coord[1] = fire_in ? in_v       : cap_v;
    g_log2[0]  = fire_in ? cfg_log2_w : cap_lw;
    g_log2[1]  = fire_in ? cfg_log2_h : cap_lh;
    g_level    = fire_in ? lvl_in     : req_level + LW'(1);
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    mip_axis_geom #(.LW(LW), .MAXLOG(MAXLOG)) u_geom (
      .coord     (g_coord[a]),
      .log2_base (g_log2[a]),
      .level     (g_level),
      .t0        (g_t0[a]),
      .t1        (g_t1[a]),
      .w         (g_w[a])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_level <= '0;
      req_x0    <= '0;
      req_x1    <= '0;
      req_y0    <= '0;
      req_y1    <= '0;
      req_wx    <= '0;
      req_wy    <= '0;
      req_lerp  <= '0;
      req_last  <= 1'b0;
      cap_u     <= '0;
      cap_v     <= '0;
      cap_lw    <= '0;
      cap_lh    <= '0;
    end else if (fire_in) begin
      state     <= S_LVL0;
      req_valid <= 1'b1;
      req_level <= lvl_in;
      req_x0    <= g_t0[0];
      req_x1    <= g_t1[0];
      req_y0    <= g_t0[1];
      req_y1    <= g_t1[1];
      req_wx    <= g_w[0];
      req_wy    <= g_w[1];
      req_lerp  <= tri_in ? in_lod_frac : 8'd0;
      req_last  <= !tri_in;
      cap_u     <= in_u;
      cap_v     <= in_v;
      cap_lw    <= cfg_log2_w;
      cap_lh    <= cfg_log2_h;
    end else if (fire_req) begin
      if (!req_last) begin
        // Second level of a trilinear fragment; req_lerp carries over.
        state     <= S_LVL1;
        req_level <= g_level;
        req_x0    <= g_t0[0];
        req_x1    <= g_t1[0];
        req_y0    <= g_t0[1];
        req_y1    <= g_t1[1];
        req_wx    <= g_w[0];
        req_wy    <= g_w[1];
        req_last  <= 1'b1;
      end else begin
        state     <= S_IDLE;
        req_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mip_trilinear_seq.sv
// Randomized scoreboard bench for mip_trilinear_seq. The stimulus side pushes
// the expected requests of each accepted fragment. A monitor pops them and
// compares on every request handshake. It also checks that the outputs hold
// steady while a request is stalled.
module tb_mip_trilinear_seq;
  localparam int LEVELS = 12;
  localparam int MAXLOG = 11;
  localparam int LW     = 4;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [15:0]       in_u, in_v;
  logic [LW-1:0]     in_lod_int;
  logic [7:0]        in_lod_frac;
  logic [3:0]        cfg_log2_w, cfg_log2_h;
  logic [LW-1:0]     cfg_max_level;
  logic              req_valid, req_ready;
  logic [LW-1:0]     req_level;
  logic [MAXLOG-1:0] req_x0, req_x1, req_y0, req_y1;
  logic [7:0]        req_wx, req_wy, req_lerp;
  logic              req_last;

  typedef struct packed {
    logic [LW-1:0]     level;
    logic [MAXLOG-1:0] x0, x1, y0, y1;
    logic [7:0]        wx, wy, lerp;
    logic              last;
  } req_t;

  req_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   rnd_rr  = 0;

  mip_trilinear_seq #(.LEVELS(LEVELS), .MAXLOG(MAXLOG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_u(in_u), .in_v(in_v), .in_lod_int(in_lod_int), .in_lod_frac(in_lod_frac),
    .cfg_log2_w(cfg_log2_w), .cfg_log2_h(cfg_log2_h), .cfg_max_level(cfg_max_level),
    .req_valid(req_valid), .req_ready(req_ready), .req_level(req_level),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .req_wx(req_wx), .req_wy(req_wy), .req_lerp(req_lerp), .req_last(req_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic req_t dut_out();
    req_t r;
    r.level = req_level; r.x0 = req_x0; r.x1 = req_x1; r.y0 = req_y0; r.y1 = req_y1;
    r.wx = req_wx; r.wy = req_wy; r.lerp = req_lerp; r.last = req_last;
    return r;
  endfunction

  // Texel position in 1/65536 texel units, sample centres at +0.5, floored
  // and wrapped with a true modulo.
  function automatic void axis_model(input int coord, input int log2b, input int level,
                                     output int t0, output int t1, output int w);
    int lw, wd;
    longint pos, fl, fr;
    lw  = (log2b > level) ? log2b - level : 0;
    wd  = 1 << lw;
    pos = longint'(coord) * wd - 32768;
    fl  = (pos >= 0) ? pos / 65536 : -((-pos + 65535) / 65536);
    fr  = pos - fl * 65536;
    t0  = int'(((fl % wd) + wd) % wd);
    t1  = (t0 + 1) % wd;
    w   = (lw == 0) ? 0 : int'(fr / 256);
  endfunction

  function automatic req_t mk_req(input int u, input int v, input int lvl,
                                  input int lerp, input bit last);
    req_t r;
    int a0, a1, aw;
    axis_model(u, int'(cfg_log2_w), lvl, a0, a1, aw);
    r.x0 = MAXLOG'(a0); r.x1 = MAXLOG'(a1); r.wx = 8'(aw);
    axis_model(v, int'(cfg_log2_h), lvl, a0, a1, aw);
    r.y0 = MAXLOG'(a0); r.y1 = MAXLOG'(a1); r.wy = 8'(aw);
    r.level = LW'(lvl); r.lerp = 8'(lerp); r.last = last;
    return r;
  endfunction

  task automatic push_model(input int u, input int v, input int lod, input int frac);
    int mx, lvl;
    bit tri_f;
    mx    = int'(cfg_max_level);
    lvl   = (lod < mx) ? lod : mx;
    tri_f = (frac != 0) && (lod < mx);
    exp_q.push_back(mk_req(u, v, lvl, tri_f ? frac : 0, !tri_f));
    if (tri_f) exp_q.push_back(mk_req(u, v, lvl + 1, frac, 1'b1));
  endtask

  task automatic set_frag(input int u, input int v, input int lod, input int frac);
    in_u = 16'(u); in_v = 16'(v); in_lod_int = LW'(lod); in_lod_frac = 8'(frac);
  endtask

  task automatic send(input int u, input int v, input int lod, input int frac);
    int  cyc;
    bit  done;
    cyc = 0; done = 0;
    set_frag(u, v, lod, frac);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(u, v, lod, frac);
        done = 1;
      end else if (++cyc > 300) begin
        fail_now("in_ready wait");
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || req_valid) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 500) fail_now("drain");
  endtask

  task automatic set_cfg(input int lw, input int lh, input int mx);
    cfg_log2_w = 4'(lw); cfg_log2_h = 4'(lh); cfg_max_level = LW'(mx);
  endtask

  // Monitor: compare every request handshake and check stall stability.
  initial begin
    req_t prev_o, got, exp;
    bit   prev_stall;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        got = dut_out();
        if (prev_stall) check("stall hold", {req_valid, got}, {1'b1, prev_o});
        if (req_valid && req_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected request: got %h, none expected", got);
          end else begin
            exp = exp_q.pop_front();
            check("request", got, exp);
          end
        end
        prev_stall = req_valid && !req_ready;
        prev_o     = got;
      end
    end
  end

  // Random back-pressure while rnd_rr is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rr) req_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int u, v, lod, frac;
    rst = 1'b1; in_valid = 1'b0; req_ready = 1'b1;
    set_frag(0, 0, 0, 0);
    set_cfg(8, 8, 8);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset req_valid", req_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b0);
    check("reset fields", dut_out(), '0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed footprints
    send(16'h8000, 16'h8000, 2, 0);
    send(16'h8000, 16'h8000, 2, 8'h40);
    drain();
    set_cfg(4, 4, 8);
    send(0, 0, 0, 0);
    send(16'hFFFF, 16'hFFFF, 0, 0);
    drain();
    set_cfg(8, 8, 8);
    send(16'h8000, 16'h8000, 10, 8'h80);
    drain();

    // Two trilinear fragments with back-pressure, then a full-rate burst
    req_ready = 1'b0;
    send(16'h4000, 16'hC000, 1, 8'h20);
    set_frag(16'h1357, 16'h9ABC, 3, 8'h90);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall in_ready", in_ready, 1'b0);
      check("stall req_valid", req_valid, 1'b1);
      @(posedge clk); #1;
    end
    req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("burst req_valid", req_valid, 1'b1);
      check("burst in_ready", in_ready, (k == 1 || k == 3));
      if (k == 1 && in_ready && in_valid) push_model(16'h1357, 16'h9ABC, 3, 8'h90);
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    // Randomized fragments under random back-pressure
    rnd_rr = 1;
    for (int b = 0; b < 12; b++) begin
      set_cfg($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      for (int f = 0; f < 12; f++) begin
        u    = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 16'hFFFF)
                                           : int'($urandom_range(0, 16'hFFFF));
        v    = int'($urandom_range(0, 16'hFFFF));
        lod  = int'($urandom_range(0, 15));
        frac = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        send(u, v, lod, frac);
      end
      drain();
    end
    rnd_rr = 0;
    @(posedge clk); #1;
    req_ready = 1'b1;

    // Reset while the second-level request is stalled
    set_cfg(8, 8, 8);
    req_ready = 1'b0;
    send(16'h1234, 16'h5678, 4, 8'h33);
    req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    check("lvl1 stalled valid", {req_valid, req_last}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst drops req_valid", req_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post-reset idle", {req_valid, in_ready}, 2'b01);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
